memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles to wait for i_dmem_ack before aborting the access.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port i_ex_valid, input, 1 bit: EX stage presents an instruction.
REQ-005 SHALL have port i_ex_mem_read / i_ex_mem_write, input, 1 bit each: load / store.
REQ-006 SHALL have port i_ex_funct3, input, 3 bits: access size and sign (LB, LH, LW, LBU, LHU, SB, SH, SW encodings).
REQ-007 SHALL have port i_ex_result, input, 32 bits: ALU result, also the byte address.
REQ-008 SHALL have port i_ex_store_data, input, 32 bits: rs2 value.
REQ-009 SHALL have ports i_ex_pc_plus_4 (input, 32 bits), i_ex_rd (input, 5 bits), i_ex_reg_write (input, 1 bit), i_ex_mem_to_reg (input, 1 bit) and i_ex_rw_sel (input, 2 bits): sideband passed to writeback.
REQ-010 SHALL have ports o_dmem_req (output, 1 bit), o_dmem_we (output, 1 bit), o_dmem_addr (output, 32 bits; word-aligned, bits[1:0]=0), o_dmem_wdata (output, 32 bits) and o_dmem_wstrb (output, 4 bits): data-memory request.
REQ-011 SHALL have ports i_dmem_rdata (input, 32 bits) and i_dmem_ack (input, 1 bit): data-memory response.
REQ-012 SHALL have port o_ma_stall, output, 1 bit: freeze upstream stages.
REQ-013 SHALL have ports o_ma_reg_write (output, 1 bit), o_ma_rd (output, 5 bits), o_ma_mem_to_reg (output, 1 bit), o_ma_rw_sel (output, 2 bits), o_ma_pc_plus_4 (output, 32 bits), o_ma_read_data (output, 32 bits) and o_ma_result (output, 32 bits): registered MA/WB outputs feeding writeback.
REQ-014 SHALL have port o_ma_bus_err, output, 1 bit: one-cycle pulse on access timeout.

Function
REQ-015 SHALL implement an FSM with states IDLE and WAIT.
REQ-016 In IDLE, for a valid non-memory instruction: SHALL register the sideband and i_ex_result into the o_ma_* outputs on the next edge (latency 1) and keep o_ma_stall low.
REQ-017 In IDLE, for a valid load or store: SHALL assert o_dmem_req combinationally, assert o_ma_stall, and enter WAIT unless i_dmem_ack is already high in the same cycle.
REQ-018 While WAIT: SHALL hold o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_wdata and o_dmem_wstrb stable; SHALL keep o_ma_stall high; SHALL drive o_ma_reg_write low (bubble).
REQ-019 SHALL complete a transfer on the cycle i_dmem_ack=1 with o_dmem_req=1: register the writeback outputs, drop o_ma_stall in that cycle, and return to IDLE.
REQ-020 SHALL replicate store data per lane: SB byte ×4 with one-hot wstrb by addr[1:0]; SH half ×2 with wstrb 0011/1100 by addr[1]; SW wstrb 1111.
REQ-021 Loads SHALL set wstrb 0000 and o_dmem_we=0; o_ma_read_data SHALL be the addressed lane shifted to bit 0, sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-022 A cycle counter SHALL start at 0 on entry to WAIT; reaching TIMEOUT_CYCLES without ack SHALL pulse o_ma_bus_err, deassert o_dmem_req, squash writeback (o_ma_reg_write=0) and return to IDLE.
REQ-023 i_ex_valid=0 SHALL produce a bubble: o_ma_reg_write=0 and no request.
REQ-024 An i_dmem_ack outside an outstanding request SHALL be ignored.

Reset
REQ-025 Asserting i_rst at any time, including mid-access, SHALL force IDLE, zero the counter, and drive every output to 0 immediately; no request is replayed after reset.

Configuration
REQ-026 With MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 SHALL issue no request, pulse o_ma_bus_err the next cycle and squash writeback; without it, the address SHALL be forced to the natural alignment and the access performed.

Verification
REQ-027 ALU op, result 0x0000_1234, rd 5, reg_write 1 -> next cycle o_ma_result 0x1234, o_ma_rd 5, o_ma_stall 0.
REQ-028 LB at addr 0x103, ack after 2 wait cycles with rdata 0x80FF_FFFF -> o_ma_stall high for 3 cycles, then o_ma_read_data 0xFFFF_FF80.
REQ-029 SH at addr 0x202, data 0x0000_ABCD, immediate ack -> o_dmem_wdata 0xABCD_ABCD, wstrb 1100, o_dmem_addr 0x200, o_dmem_we 1.
REQ-030 LW with no ack -> after 16 cycles o_ma_bus_err pulses once, o_ma_reg_write 0, FSM back in IDLE.
REQ-031 i_rst asserted in WAIT -> o_dmem_req and o_ma_stall drop at once; a later ack is ignored.
REQ-032 With MEM_MISALIGN_TRAP_EN, LW at 0x101 -> no o_dmem_req, o_ma_bus_err pulse next cycle.

Source files
------------

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MA stage: data-memory request FSM, lane formatting, ack timeout; optional MEM_MISALIGN_TRAP_EN
module memory_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_mem_write,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_result,
  input  logic [31:0] i_ex_store_data,
  input  logic [31:0] i_ex_pc_plus_4,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_reg_write,
  input  logic        i_ex_mem_to_reg,
  input  logic [1:0]  i_ex_rw_sel,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  output logic        o_ma_stall,
  output logic        o_ma_reg_write,
  output logic [4:0]  o_ma_rd,
  output logic        o_ma_mem_to_reg,
  output logic [1:0]  o_ma_rw_sel,
  output logic [31:0] o_ma_pc_plus_4,
  output logic [31:0] o_ma_read_data,
  output logic [31:0] o_ma_result,
  output logic        o_ma_bus_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  // Request and writeback context captured at issue so WAIT never depends on EX inputs
  logic        h_we;
  logic [29:0] h_addr;
  logic [31:0] h_wdata;
  logic [3:0]  h_wstrb;
  logic [2:0]  h_funct3;
  logic [1:0]  h_lane;
  logic [4:0]  h_rd;
  logic        h_reg_write;
  logic        h_mem_to_reg;
  logic [1:0]  h_rw_sel;
  logic [31:0] h_pc_plus_4;
  logic [31:0] h_result;

  logic        ex_mem;
  logic        ex_trap;
  logic        issue;
  logic        in_wait;
  logic        busy;
  logic        timeout_hit;
  logic [35:0] ex_lanes;
  logic [3:0]  ex_wstrb;
  logic [31:0] ex_wdata;

  logic [2:0]  c_funct3;
  logic [1:0]  c_lane;
  logic [4:0]  c_rd;
  logic        c_reg_write;
  logic        c_mem_to_reg;
  logic [1:0]  c_rw_sel;
  logic [31:0] c_pc_plus_4;
  logic [31:0] c_result;

  // Replicate store data across lanes; returns {wstrb, wdata}
  function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] data);
    logic [3:0]  strb;
    logic [31:0] wd;
    case (f3[1:0])
      2'b00: begin
        wd   = {4{data[7:0]}};
        strb = 4'b0001 << lane;
      end
      2'b01: begin
        wd   = {2{data[15:0]}};
        strb = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wd   = data;
        strb = 4'b1111;
      end
    endcase
    return {strb, wd};
  endfunction

  // Pick the addressed lane, move it to bit 0 and extend per funct3
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  assign ex_mem = i_ex_valid & (i_ex_mem_read | i_ex_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  logic ex_misalign;
  assign ex_misalign = (i_ex_funct3[1:0] == 2'b01 && i_ex_result[0]) ||
                       (i_ex_funct3[1] && i_ex_result[1:0] != 2'b00);
  assign ex_trap = (state == S_IDLE) & ex_mem & ex_misalign;
`else
  assign ex_trap = 1'b0;
`endif

  assign issue       = (state == S_IDLE) & ex_mem & ~ex_trap;
  assign in_wait     = (state == S_WAIT);
  assign busy        = issue | in_wait;
  assign timeout_hit = in_wait & ~i_dmem_ack & (wait_cnt == CNT_LAST);

  assign ex_lanes = store_lanes(i_ex_funct3, i_ex_result[1:0], i_ex_store_data);
  assign ex_wdata = ex_lanes[31:0];
  assign ex_wstrb = i_ex_mem_write ? ex_lanes[35:32] : 4'b0000;

  // Bus outputs: live from EX on the issue cycle, from the capture registers while waiting
  assign o_dmem_req   = ~i_rst & busy;
  assign o_dmem_we    = ~i_rst & (in_wait ? h_we : (issue & i_ex_mem_write));
  assign o_dmem_addr  = i_rst ? 32'h0 : in_wait ? {h_addr, 2'b00} :
                        issue ? {i_ex_result[31:2], 2'b00} : 32'h0;
  assign o_dmem_wdata = i_rst ? 32'h0 : in_wait ? h_wdata : issue ? ex_wdata : 32'h0;
  assign o_dmem_wstrb = i_rst ? 4'h0 : in_wait ? h_wstrb : issue ? ex_wstrb : 4'h0;
  assign o_ma_stall   = ~i_rst & busy & ~i_dmem_ack & ~timeout_hit;

  assign c_funct3     = in_wait ? h_funct3     : i_ex_funct3;
  assign c_lane       = in_wait ? h_lane       : i_ex_result[1:0];
  assign c_rd         = in_wait ? h_rd         : i_ex_rd;
  assign c_reg_write  = in_wait ? h_reg_write  : i_ex_reg_write;
  assign c_mem_to_reg = in_wait ? h_mem_to_reg : i_ex_mem_to_reg;
  assign c_rw_sel     = in_wait ? h_rw_sel     : i_ex_rw_sel;
  assign c_pc_plus_4  = in_wait ? h_pc_plus_4  : i_ex_pc_plus_4;
  assign c_result     = in_wait ? h_result     : i_ex_result;

  // FSM, timeout counter, request capture and MA/WB output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      h_we            <= 1'b0;
      h_addr          <= '0;
      h_wdata         <= '0;
      h_wstrb         <= '0;
      h_funct3        <= '0;
      h_lane          <= '0;
      h_rd            <= '0;
      h_reg_write     <= 1'b0;
      h_mem_to_reg    <= 1'b0;
      h_rw_sel        <= '0;
      h_pc_plus_4     <= '0;
      h_result        <= '0;
      o_ma_reg_write  <= 1'b0;
      o_ma_rd         <= '0;
      o_ma_mem_to_reg <= 1'b0;
      o_ma_rw_sel     <= '0;
      o_ma_pc_plus_4  <= '0;
      o_ma_read_data  <= '0;
      o_ma_result     <= '0;
      o_ma_bus_err    <= 1'b0;
    end else begin
      o_ma_reg_write <= 1'b0;
      o_ma_bus_err   <= 1'b0;
      if (in_wait) begin
        if (i_dmem_ack) begin
          o_ma_reg_write  <= c_reg_write;
          o_ma_rd         <= c_rd;
          o_ma_mem_to_reg <= c_mem_to_reg;
          o_ma_rw_sel     <= c_rw_sel;
          o_ma_pc_plus_4  <= c_pc_plus_4;
          o_ma_result     <= c_result;
          o_ma_read_data  <= load_extract(c_funct3, c_lane, i_dmem_rdata);
          state           <= S_IDLE;
        end else if (timeout_hit) begin
          o_ma_bus_err <= 1'b1;
          wait_cnt     <= '0;
          state        <= S_IDLE;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else if (ex_trap) begin
        o_ma_bus_err <= 1'b1;
      end else if (issue) begin
        if (i_dmem_ack) begin
          o_ma_reg_write  <= c_reg_write;
          o_ma_rd         <= c_rd;
          o_ma_mem_to_reg <= c_mem_to_reg;
          o_ma_rw_sel     <= c_rw_sel;
          o_ma_pc_plus_4  <= c_pc_plus_4;
          o_ma_result     <= c_result;
          o_ma_read_data  <= load_extract(c_funct3, c_lane, i_dmem_rdata);
        end else begin
          h_we         <= i_ex_mem_write;
          h_addr       <= i_ex_result[31:2];
          h_wdata      <= ex_wdata;
          h_wstrb      <= ex_wstrb;
          h_funct3     <= i_ex_funct3;
          h_lane       <= i_ex_result[1:0];
          h_rd         <= i_ex_rd;
          h_reg_write  <= i_ex_reg_write;
          h_mem_to_reg <= i_ex_mem_to_reg;
          h_rw_sel     <= i_ex_rw_sel;
          h_pc_plus_4  <= i_ex_pc_plus_4;
          h_result     <= i_ex_result;
          wait_cnt     <= '0;
          state        <= S_WAIT;
        end
      end else if (i_ex_valid) begin
        o_ma_reg_write  <= c_reg_write;
        o_ma_rd         <= c_rd;
        o_ma_mem_to_reg <= c_mem_to_reg;
        o_ma_rw_sel     <= c_rw_sel;
        o_ma_pc_plus_4  <= c_pc_plus_4;
        o_ma_result     <= c_result;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - self-checking bench for memory_access
module tb_memory_access;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ex_valid, i_ex_mem_read, i_ex_mem_write;
  logic [2:0]  i_ex_funct3;
  logic [31:0] i_ex_result, i_ex_store_data, i_ex_pc_plus_4;
  logic [4:0]  i_ex_rd;
  logic        i_ex_reg_write, i_ex_mem_to_reg;
  logic [1:0]  i_ex_rw_sel;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic [31:0] i_dmem_rdata;
  logic        i_dmem_ack;
  logic        o_ma_stall, o_ma_reg_write, o_ma_mem_to_reg, o_ma_bus_err;
  logic [4:0]  o_ma_rd;
  logic [1:0]  o_ma_rw_sel;
  logic [31:0] o_ma_pc_plus_4, o_ma_read_data, o_ma_result;

  always #5 i_clk = ~i_clk;

  memory_access #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ex_valid(i_ex_valid), .i_ex_mem_read(i_ex_mem_read), .i_ex_mem_write(i_ex_mem_write),
    .i_ex_funct3(i_ex_funct3), .i_ex_result(i_ex_result), .i_ex_store_data(i_ex_store_data),
    .i_ex_pc_plus_4(i_ex_pc_plus_4), .i_ex_rd(i_ex_rd), .i_ex_reg_write(i_ex_reg_write),
    .i_ex_mem_to_reg(i_ex_mem_to_reg), .i_ex_rw_sel(i_ex_rw_sel),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_ack(i_dmem_ack),
    .o_ma_stall(o_ma_stall), .o_ma_reg_write(o_ma_reg_write), .o_ma_rd(o_ma_rd),
    .o_ma_mem_to_reg(o_ma_mem_to_reg), .o_ma_rw_sel(o_ma_rw_sel),
    .o_ma_pc_plus_4(o_ma_pc_plus_4), .o_ma_read_data(o_ma_read_data),
    .o_ma_result(o_ma_result), .o_ma_bus_err(o_ma_bus_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] result;
    logic [31:0] pc4;
    logic [31:0] read_data;
    logic        chk_rdata;
  } wb_t;

  wb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    case (f3[1:0])
      2'b00:   sh = rdata >> (addr[1:0] * 8);
      2'b01:   sh = rdata >> (addr[1] * 16);
      default: sh = rdata;
    endcase
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b001:  return 32'($signed(sh[15:0]));
      3'b100:  return 32'(sh[7:0]);
      3'b101:  return 32'(sh[15:0]);
      default: return sh;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d,
                             output logic [31:0] wd, output logic [3:0] ws);
    case (f3[1:0])
      2'b00: begin wd = {4{d[7:0]}}; ws = 4'(1 << addr[1:0]); end
      2'b01: begin wd = {2{d[15:0]}}; ws = addr[1] ? 4'hC : 4'h3; end
      default: begin wd = d; ws = 4'hF; end
    endcase
  endtask

  task automatic set_idle();
    i_ex_valid = 0; i_ex_mem_read = 0; i_ex_mem_write = 0; i_ex_funct3 = 0;
    i_ex_result = 0; i_ex_store_data = 0; i_ex_pc_plus_4 = 0; i_ex_rd = 0;
    i_ex_reg_write = 0; i_ex_mem_to_reg = 0; i_ex_rw_sel = 0;
    i_dmem_ack = 0; i_dmem_rdata = 0;
  endtask

  task automatic drive_ex(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] res, input logic [31:0] sdata, input logic [4:0] rd,
                          input logic regwr, input logic [31:0] pc4);
    i_ex_valid = 1; i_ex_mem_read = rd_en; i_ex_mem_write = wr_en; i_ex_funct3 = f3;
    i_ex_result = res; i_ex_store_data = sdata; i_ex_rd = rd; i_ex_reg_write = regwr;
    i_ex_pc_plus_4 = pc4; i_ex_mem_to_reg = rd_en; i_ex_rw_sel = rd_en ? 2'b01 : 2'b10;
  endtask

  task automatic test_reset();
    i_rst = 1;
    drive_ex(1, 1, 3'b010, 32'h104, 32'hFFFF_FFFF, 5'd3, 1, 32'h8);
    i_dmem_ack = 1;
    @(posedge i_clk); #1;
    checks++;
    if ({o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_wstrb, o_ma_stall} !== '0) begin
      failures++;
      $display("FAIL reset_bus got req=%b we=%b addr=%h wdata=%h wstrb=%b stall=%b exp all 0",
               o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_wstrb, o_ma_stall);
    end
    checks++;
    if ({o_ma_reg_write, o_ma_rd, o_ma_mem_to_reg, o_ma_rw_sel, o_ma_pc_plus_4,
         o_ma_read_data, o_ma_result, o_ma_bus_err} !== '0) begin
      failures++;
      $display("FAIL reset_wb got rw=%b rd=%0d res=%h rdata=%h err=%b exp all 0",
               o_ma_reg_write, o_ma_rd, o_ma_result, o_ma_read_data, o_ma_bus_err);
    end
    set_idle();
    i_rst = 0;
  endtask

  task automatic test_alu();
    wb_t e;
    drive_ex(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 32'h0000_0104);
    sb_q.push_back('{rd: 5'd5, reg_write: 1'b1, result: 32'h1234, pc4: 32'h104,
                     read_data: 32'h0, chk_rdata: 1'b0});
    #3;
    checks++;
    if (o_ma_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL alu_nostall got stall=%b req=%b exp 0 0", o_ma_stall, o_dmem_req);
    end
    @(posedge i_clk); #1;
    e = sb_q.pop_front();
    checks++;
    if (o_ma_result !== e.result || o_ma_rd !== e.rd || o_ma_reg_write !== e.reg_write ||
        o_ma_pc_plus_4 !== e.pc4 || o_ma_rw_sel !== 2'b10) begin
      failures++;
      $display("FAIL alu_wb got res=%h rd=%0d rw=%b pc4=%h sel=%b exp res=%h rd=%0d rw=%b pc4=%h sel=10",
               o_ma_result, o_ma_rd, o_ma_reg_write, o_ma_pc_plus_4, o_ma_rw_sel,
               e.result, e.rd, e.reg_write, e.pc4);
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    wb_t e;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] r;
      r = $urandom;
      drive_ex(0, 0, 3'b000, r, 32'h0, 5'(i + 10), 1'(i % 2), 32'(i * 4));
      sb_q.push_back('{rd: 5'(i + 10), reg_write: 1'(i % 2), result: r, pc4: 32'(i * 4),
                       read_data: 32'h0, chk_rdata: 1'b0});
      @(posedge i_clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (o_ma_result !== e.result || o_ma_rd !== e.rd || o_ma_reg_write !== e.reg_write) begin
        failures++;
        $display("FAIL b2b_%0d got res=%h rd=%0d rw=%b exp res=%h rd=%0d rw=%b", i,
                 o_ma_result, o_ma_rd, o_ma_reg_write, e.result, e.rd, e.reg_write);
      end
    end
    set_idle();
  endtask

  task automatic test_load_wait();
    wb_t e;
    int  stall_cycles = 0;
    bit  done = 0;
    drive_ex(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1, 32'h200);
    sb_q.push_back('{rd: 5'd7, reg_write: 1'b1, result: 32'h103, pc4: 32'h200,
                     read_data: model_load(3'b000, 32'h103, 32'h80FF_FFFF), chk_rdata: 1'b1});
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      i_dmem_ack   = (cyc == 3);
      i_dmem_rdata = (cyc == 3) ? 32'h80FF_FFFF : 32'h1111_2222;
      #3;
      if (o_ma_stall) stall_cycles++;
      else done = 1;
      if (cyc == 0 || cyc == 2) begin
        checks++;
        if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h100 || o_dmem_we !== 1'b0 ||
            o_dmem_wstrb !== 4'h0) begin
          failures++;
          $display("FAIL lb_req_c%0d got req=%b addr=%h we=%b wstrb=%b exp 1 00000100 0 0000",
                   cyc, o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_wstrb);
        end
      end
      if (cyc == 1 || cyc == 2) begin
        checks++;
        if (o_ma_reg_write !== 1'b0) begin
          failures++;
          $display("FAIL lb_bubble_c%0d got reg_write=%b exp 0", cyc, o_ma_reg_write);
        end
      end
      @(posedge i_clk); #1;
    end
    i_dmem_ack = 0;
    set_idle();
    e = sb_q.pop_front();
    checks++;
    if (!done || stall_cycles != 3) begin
      failures++;
      $display("FAIL lb_stall_cycles got %0d done=%0d exp 3 done=1", stall_cycles, done);
    end
    checks++;
    if (o_ma_read_data !== e.read_data || o_ma_rd !== e.rd || o_ma_reg_write !== e.reg_write) begin
      failures++;
      $display("FAIL lb_wb got rdata=%h rd=%0d rw=%b exp rdata=%h rd=%0d rw=%b",
               o_ma_read_data, o_ma_rd, o_ma_reg_write, e.read_data, e.rd, e.reg_write);
    end
  endtask

  task automatic test_loads_immediate();
    logic [2:0]  f3s [4] = '{3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ads [4] = '{32'h101, 32'h202, 32'h300, 32'h404};
    logic [31:0] rds [4] = '{32'h1234_8056, 32'h8001_7FFF, 32'h0000_9ABC, 32'hDEAD_BEEF};
    wb_t e;
    for (int i = 0; i < 4; i++) begin
      drive_ex(1, 0, f3s[i], ads[i], 32'h0, 5'(20 + i), 1, 32'h300);
      i_dmem_ack = 1; i_dmem_rdata = rds[i];
      sb_q.push_back('{rd: 5'(20 + i), reg_write: 1'b1, result: ads[i], pc4: 32'h300,
                       read_data: model_load(f3s[i], ads[i], rds[i]), chk_rdata: 1'b1});
      #3;
      checks++;
      if (o_dmem_req !== 1'b1 || o_ma_stall !== 1'b0 || o_dmem_addr !== {ads[i][31:2], 2'b00}) begin
        failures++;
        $display("FAIL ld_imm_req_%0d got req=%b stall=%b addr=%h exp 1 0 %h", i,
                 o_dmem_req, o_ma_stall, o_dmem_addr, {ads[i][31:2], 2'b00});
      end
      @(posedge i_clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (o_ma_read_data !== e.read_data || o_ma_reg_write !== 1'b1 || o_ma_rd !== e.rd) begin
        failures++;
        $display("FAIL ld_imm_wb_%0d got rdata=%h rw=%b rd=%0d exp rdata=%h rw=1 rd=%0d", i,
                 o_ma_read_data, o_ma_reg_write, o_ma_rd, e.read_data, e.rd);
      end
    end
    set_idle();
  endtask

  task automatic test_stores();
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ads [3] = '{32'h101, 32'h202, 32'h300};
    logic [31:0] dts [3] = '{32'h0000_005A, 32'h0000_ABCD, 32'h1234_5678};
    logic [31:0] wd;
    logic [3:0]  ws;
    for (int i = 0; i < 3; i++) begin
      drive_ex(0, 1, f3s[i], ads[i], dts[i], 5'd0, 0, 32'h0);
      i_dmem_ack = 1;
      model_store(f3s[i], ads[i], dts[i], wd, ws);
      #3;
      checks++;
      if (o_dmem_wdata !== wd || o_dmem_wstrb !== ws || o_dmem_we !== 1'b1 ||
          o_dmem_addr !== {ads[i][31:2], 2'b00} || o_ma_stall !== 1'b0) begin
        failures++;
        $display("FAIL st_%0d got wdata=%h wstrb=%b we=%b addr=%h stall=%b exp %h %b 1 %h 0", i,
                 o_dmem_wdata, o_dmem_wstrb, o_dmem_we, o_dmem_addr, o_ma_stall,
                 wd, ws, {ads[i][31:2], 2'b00});
      end
      @(posedge i_clk); #1;
      checks++;
      if (o_ma_reg_write !== 1'b0) begin
        failures++;
        $display("FAIL st_wb_%0d got reg_write=%b exp 0", i, o_ma_reg_write);
      end
    end
    set_idle();
  endtask

  task automatic test_store_hold();
    drive_ex(0, 1, 3'b010, 32'h40C, 32'hCAFE_F00D, 5'd0, 0, 32'h0);
    @(posedge i_clk); #1;
    i_ex_store_data = 32'h0BAD_0BAD; i_ex_result = 32'h999; i_ex_funct3 = 3'b000;
    #3;
    checks++;
    if (o_dmem_req !== 1'b1 || o_dmem_wdata !== 32'hCAFE_F00D || o_dmem_addr !== 32'h40C ||
        o_dmem_wstrb !== 4'hF || o_dmem_we !== 1'b1 || o_ma_stall !== 1'b1) begin
      failures++;
      $display("FAIL st_hold got req=%b wdata=%h addr=%h wstrb=%b we=%b stall=%b exp 1 cafef00d 0000040c 1111 1 1",
               o_dmem_req, o_dmem_wdata, o_dmem_addr, o_dmem_wstrb, o_dmem_we, o_ma_stall);
    end
    @(posedge i_clk); #1;
    i_dmem_ack = 1;
    #3;
    checks++;
    if (o_ma_stall !== 1'b0) begin
      failures++;
      $display("FAIL st_hold_ack got stall=%b exp 0", o_ma_stall);
    end
    @(posedge i_clk); #1;
    set_idle();
    #3;
    checks++;
    if (o_dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL st_hold_idle got req=%b exp 0", o_dmem_req);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_timeout();
    wb_t e;
    int  edges = 0;
    int  stall_hi = 0;
    bit  seen = 0;
    bit  any_wb = 0;
    drive_ex(1, 0, 3'b010, 32'h500, 32'h0, 5'd9, 1, 32'h600);
    for (int cyc = 0; cyc < 40; cyc++) begin
      #3;
      if (o_ma_stall) stall_hi++;
      else i_ex_valid = 0;
      @(posedge i_clk); #1;
      edges++;
      if (o_ma_reg_write) any_wb = 1;
      if (o_ma_bus_err) begin
        seen = 1;
        break;
      end
    end
    i_ex_valid = 0;
    checks++;
    if (!seen || edges != 17 || stall_hi != 16) begin
      failures++;
      $display("FAIL timeout_timing got seen=%0d edges=%0d stall_cycles=%0d exp 1 17 16",
               seen, edges, stall_hi);
    end
    checks++;
    if (any_wb || o_ma_reg_write !== 1'b0) begin
      failures++;
      $display("FAIL timeout_squash got reg_write_seen=%0d exp 0", any_wb);
    end
    #3;
    checks++;
    if (o_dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_req got req=%b exp 0", o_dmem_req);
    end
    drive_ex(0, 0, 3'b000, 32'h0000_7777, 32'h0, 5'd4, 1, 32'h0);
    sb_q.push_back('{rd: 5'd4, reg_write: 1'b1, result: 32'h7777, pc4: 32'h0,
                     read_data: 32'h0, chk_rdata: 1'b0});
    @(posedge i_clk); #1;
    e = sb_q.pop_front();
    checks++;
    if (o_ma_bus_err !== 1'b0 || o_ma_result !== e.result || o_ma_reg_write !== e.reg_write) begin
      failures++;
      $display("FAIL timeout_after got err=%b res=%h rw=%b exp err=0 res=%h rw=%b",
               o_ma_bus_err, o_ma_result, o_ma_reg_write, e.result, e.reg_write);
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    bit replay = 0;
    drive_ex(1, 0, 3'b010, 32'h600, 32'h0, 5'd11, 1, 32'h0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    #2;
    i_rst = 1;
    #1;
    checks++;
    if (o_dmem_req !== 1'b0 || o_ma_stall !== 1'b0 || o_ma_reg_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got req=%b stall=%b rw=%b exp 0 0 0", o_dmem_req, o_ma_stall, o_ma_reg_write);
    end
    set_idle();
    @(posedge i_clk); #1;
    i_rst = 0;
    i_dmem_ack = 1; i_dmem_rdata = 32'h5555_AAAA;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #3;
      if (o_dmem_req !== 1'b0 || o_ma_stall !== 1'b0) replay = 1;
      @(posedge i_clk); #1;
      if (o_ma_reg_write !== 1'b0 || o_ma_bus_err !== 1'b0) replay = 1;
    end
    checks++;
    if (replay) begin
      failures++;
      $display("FAIL rst_no_replay got activity=1 exp 0");
    end
    set_idle();
  endtask

  task automatic test_bubble();
    drive_ex(1, 0, 3'b010, 32'h700, 32'h0, 5'd12, 1, 32'h0);
    i_ex_valid = 0;
    i_dmem_ack = 1;
    #3;
    checks++;
    if (o_dmem_req !== 1'b0 || o_ma_stall !== 1'b0) begin
      failures++;
      $display("FAIL bubble_req got req=%b stall=%b exp 0 0", o_dmem_req, o_ma_stall);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_ma_reg_write !== 1'b0 || o_ma_bus_err !== 1'b0) begin
      failures++;
      $display("FAIL bubble_wb got rw=%b err=%b exp 0 0", o_ma_reg_write, o_ma_bus_err);
    end
    set_idle();
  endtask

  task automatic test_misalign();
    drive_ex(1, 0, 3'b010, 32'h101, 32'h0, 5'd13, 1, 32'h0);
    i_dmem_ack = 1; i_dmem_rdata = 32'h1122_3344;
    #3;
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (o_dmem_req !== 1'b0 || o_ma_stall !== 1'b0) begin
      failures++;
      $display("FAIL trap_req got req=%b stall=%b exp 0 0", o_dmem_req, o_ma_stall);
    end
    @(posedge i_clk); #1;
    set_idle();
    checks++;
    if (o_ma_bus_err !== 1'b1 || o_ma_reg_write !== 1'b0) begin
      failures++;
      $display("FAIL trap_err got err=%b rw=%b exp 1 0", o_ma_bus_err, o_ma_reg_write);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_ma_bus_err !== 1'b0) begin
      failures++;
      $display("FAIL trap_pulse got err=%b exp 0", o_ma_bus_err);
    end
`else
    checks++;
    if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h100) begin
      failures++;
      $display("FAIL align_req got req=%b addr=%h exp 1 00000100", o_dmem_req, o_dmem_addr);
    end
    @(posedge i_clk); #1;
    set_idle();
    checks++;
    if (o_ma_read_data !== 32'h1122_3344 || o_ma_reg_write !== 1'b1 || o_ma_bus_err !== 1'b0) begin
      failures++;
      $display("FAIL align_wb got rdata=%h rw=%b err=%b exp 11223344 1 0",
               o_ma_read_data, o_ma_reg_write, o_ma_bus_err);
    end
`endif
  endtask

  initial begin
    set_idle();
    i_rst = 1;
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_wait();
    test_loads_immediate();
    test_stores();
    test_store_hold();
    test_timeout();
    test_reset_mid();
    test_bubble();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
